// File: rtl/alu_pkg.sv
// Shared encodings for the integer execute unit: ALUControl codes, FSM states, default sizes.
package alu_pkg;
    localparam int ALU_WIDTH   = 32;
    localparam int ALU_SHAMT_W = 5;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_SRL  = 3'b011;
    localparam logic [2:0] ALU_SLL  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SRA  = 3'b111;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction
endpackage

// File: rtl/alu_exec_unit_if.sv
// Operand/result handshake bundle between operand mux, execute unit and writeback.
interface alu_exec_unit_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [2:0]       ALUControl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             busy;

    modport master (output in_valid, SrcA, SrcB, ALUControl, out_ready,
                    input  in_ready, out_valid, ALUResult, Zero, busy);
    modport slave  (input  in_valid, SrcA, SrcB, ALUControl, out_ready,
                    output in_ready, out_valid, ALUResult, Zero, busy);
endinterface

// File: rtl/alu_shift_seq.sv
// Serial one-bit-per-cycle shifter; o_done is high during the cycle whose edge performs the last shift.
module alu_shift_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int SHAMT_W = ALU_SHAMT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [2:0]         i_op,
    input  logic [WIDTH-1:0]   i_data,
    input  logic [SHAMT_W-1:0] i_shamt,
    output logic [WIDTH-1:0]   o_data,
    output logic               o_done
);
    logic [WIDTH-1:0]   r_sh;
    logic [SHAMT_W-1:0] r_cnt;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   w_next;

    always_comb begin
        w_next = {1'b0, r_sh[WIDTH-1:1]};
        case (r_op)
            ALU_SLL: w_next = {r_sh[WIDTH-2:0], 1'b0};
            ALU_SRA: w_next = {r_sh[WIDTH-1], r_sh[WIDTH-1:1]};
            default: w_next = {1'b0, r_sh[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh  <= '0;
            r_cnt <= '0;
            r_op  <= ALU_SRL;
        end else if (i_load) begin
            r_sh  <= i_data;
            r_cnt <= i_shamt;
            r_op  <= i_op;
        end else if (r_cnt != '0) begin
            r_sh  <= w_next;
            r_cnt <= r_cnt - SHAMT_W'(1);
        end
    end

    assign o_data = r_sh;
    assign o_done = (r_cnt == SHAMT_W'(1));
endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle execute unit: single-cycle arithmetic/compare, serial shifts, result held until taken.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int SHAMT_W = ALU_SHAMT_W
) (
    input  logic           clk,
    input  logic           rst,
    alu_exec_unit_if.slave bus
);
    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_result;
    logic               r_sel_sh;
    logic               w_accept;
    logic               w_is_sh;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0]   w_alu;
    logic [WIDTH-1:0]   w_sh_data;
    logic               w_sh_done;
    logic [WIDTH-1:0]   w_result;

    assign w_accept = bus.in_valid & bus.in_ready;
    assign w_is_sh  = is_shift(bus.ALUControl);
    assign w_shamt  = bus.SrcB[SHAMT_W-1:0];

    always_comb begin
        w_alu = bus.SrcA;
        case (bus.ALUControl)
            ALU_ADD:  w_alu = bus.SrcA + bus.SrcB;
            ALU_SUB:  w_alu = bus.SrcA - bus.SrcB;
            ALU_XOR:  w_alu = bus.SrcA ^ bus.SrcB;
            ALU_SLT:  w_alu = {{(WIDTH-1){1'b0}}, $signed(bus.SrcA) < $signed(bus.SrcB)};
            ALU_SLTU: w_alu = {{(WIDTH-1){1'b0}}, bus.SrcA < bus.SrcB};
            default:  w_alu = bus.SrcA;
        endcase
    end

    // Shifter owns the result register for shift ops; r_sel_sh picks which register drives the output.
    alu_shift_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shift (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_accept & w_is_sh),
        .i_op   (bus.ALUControl),
        .i_data (bus.SrcA),
        .i_shamt(w_shamt),
        .o_data (w_sh_data),
        .o_done (w_sh_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_result <= '0;
            r_sel_sh <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    if (w_is_sh) begin
                        r_sel_sh <= 1'b1;
                        r_state  <= (w_shamt == '0) ? ST_DONE : ST_SHIFT;
                    end else begin
                        r_sel_sh <= 1'b0;
                        r_result <= w_alu;
                        r_state  <= ST_DONE;
                    end
                end
                ST_SHIFT: if (w_sh_done) r_state <= ST_DONE;
                ST_DONE:  if (bus.out_ready) r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_result      = r_sel_sh ? w_sh_data : r_result;
    assign bus.ALUResult = w_result;
    assign bus.Zero      = ~|w_result;
    assign bus.in_ready  = (r_state == ST_IDLE) & ~rst;
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.busy      = (r_state != ST_IDLE);
endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed corner cases, backpressure, reset abort, random ops.
module tb_alu_exec_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   rdy_force = 1;
    int   hand_cyc = -1;
    int   last_acc = 0;
    bit   head_seen = 0;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;
    exp_t q[$];

    alu_exec_unit_if #(.WIDTH(32)) bus ();
    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a ^ b;
            3'd3: return a >> sh;
            3'd4: return a << sh;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: return (a < b) ? 32'd1 : 32'd0;
            default: return $signed(a) >>> sh;
        endcase
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   n;
        bus.in_valid = 1'b1;
        bus.ALUControl = op;
        bus.SrcA = a;
        bus.SrcB = b;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 32'd1, 32'd0);
                bus.in_valid = 1'b0;
                return;
            end
        end
        e.res = model(op, a, b);
        e.lat = (op == 3'd3 || op == 3'd4 || op == 3'd7) ? int'(b % 32) : 0;
        e.acc = cyc;
        last_acc = cyc;
        q.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.ALUControl = 3'($urandom);
        bus.SrcA = $urandom;
        bus.SrcB = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_empty", q.size(), 0);
        #1;
    endtask

    // out_ready: random or forced, changed just after each rising edge
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = (rdy_force < 0) ? ($urandom % 4 != 0) : (rdy_force != 0);
        end
    end

    // Monitor: compares the presented result against the head of the scoreboard every valid cycle
    initial begin
        forever begin
            @(negedge clk);
            if (rst) continue;
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    if (!head_seen) begin
                        head_seen = 1;
                        chk("latency", cyc, q[0].acc + 1 + q[0].lat);
                    end
                    chk("result", bus.ALUResult, q[0].res);
                    chk("zero", {31'd0, bus.Zero}, {31'd0, q[0].res == 32'd0});
                    chk("in_ready_done", {31'd0, bus.in_ready}, 32'd0);
                    if (bus.out_ready) begin
                        hand_cyc = cyc;
                        void'(q.pop_front());
                        head_seen = 0;
                    end
                end
            end else if (q.size() != 0 && q[0].acc < cyc) begin
                chk("in_ready_shift", {31'd0, bus.in_ready}, 32'd0);
                chk("busy_shift", {31'd0, bus.busy}, 32'd1);
                if (cyc > q[0].acc + 1 + q[0].lat) begin
                    chk("result_timeout", 32'd1, 32'd0);
                    void'(q.pop_front());
                    head_seen = 0;
                end
            end
        end
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        bus.in_valid = 1'b0;
        bus.ALUControl = 3'd0;
        bus.SrcA = '0;
        bus.SrcB = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_result", bus.ALUResult, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;

        rdy_force = 1;
        issue(3'd0, 32'h7FFF_FFFF, 32'd1);
        issue(3'd1, 32'd5, 32'd5);
        issue(3'd5, 32'hFFFF_FFFF, 32'd1);
        issue(3'd6, 32'hFFFF_FFFF, 32'd1);
        issue(3'd7, 32'h8000_0000, 32'h0000_001F);
        issue(3'd3, 32'h8000_0000, 32'h0000_001F);
        issue(3'd4, 32'h0000_0001, 32'hFFFF_FF00);
        drain();

        // Backpressure: the XOR result must hold while the next op waits with in_valid high
        rdy_force = 0;
        bus.out_ready = 1'b0;
        issue(3'd2, 32'hF0F0_F0F0, 32'hFFFF_0000);
        fork
            begin
                repeat (6) @(posedge clk);
                #1;
                rdy_force = 1;
                bus.out_ready = 1'b1;
            end
        join_none
        issue(3'd0, 32'd100, 32'd23);
        chk("accept_after_handoff", last_acc, hand_cyc + 1);
        drain();

        // Reset in the middle of a shift discards the in-flight op
        issue(3'd4, 32'h0000_0003, 32'd10);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("abort_result", bus.ALUResult, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd0);
        q.delete();
        head_seen = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_abort", {31'd0, bus.in_ready}, 32'd1);
        repeat (15) @(posedge clk);
        #1;
        chk("no_stale_valid", {31'd0, bus.out_valid}, 32'd0);

        rdy_force = -1;
        for (int i = 0; i < 200; i++) begin
            op = 3'($urandom);
            a = $urandom;
            b = $urandom;
            if ($urandom % 4 == 0) b = a;
            if ($urandom % 2 == 0) b = (b & ~32'd31) | 32'($urandom_range(0, 4));
            issue(op, a, b);
            repeat ($urandom % 3) @(posedge clk);
            #1;
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
